// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;
   localparam int PC_INC  = 4;

   typedef enum logic {
      REQ  = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries.
// A flush empties the buffer and overrides any push or pop in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output fetch_entry_t                 head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   // Pointer and occupancy tracking; reset and flush both return to empty
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; data is not reset, validity is carried by the count
   always_ff @(posedge clk) begin
      if (push && !flush) r_mem[r_wr_ptr] <= push_data;
   end

   assign count = r_count;
   assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one outstanding request at a
// time to instruction memory, buffers responses and hands them to decode.
// A taken redirect flushes the buffer and marks any in-flight response for drop.
module fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            pc_sel,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [31:0]     if_instr,
   output logic [XLEN-1:0] if_pc
);

   import fetch_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH+1);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_req_pc;
   logic            r_drop;

   logic            w_accept;
   logic            w_push;
   logic            w_pop;
   logic [CW-1:0]   w_count;
   fetch_entry_t    w_head;
   fetch_entry_t    w_push_entry;
   logic [XLEN-1:0] w_target;

   // Low two target bits are forced to zero so every fetch is word aligned
   assign w_target = branch_target & ~XLEN'(3);

   // A request is only offered when a buffer slot is free, so the response
   // of the single outstanding request can always be pushed
   assign imem_req  = reset_n && (r_state == REQ) && (w_count < CW'(FIFO_DEPTH));
   assign imem_addr = r_pc;
   assign w_accept  = imem_req && imem_ready;

   // A response arriving together with a redirect is wrong-path and is discarded
   assign w_push       = (r_state == WAIT) && imem_rvalid && !r_drop && !pc_sel;
   assign w_push_entry = {r_req_pc, imem_rdata};
   assign w_pop        = if_valid && if_ready;

   // Fetch FSM and PC; a redirect overrides the sequential +4
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= REQ;
         r_pc    <= RESET_PC;
         r_drop  <= 1'b0;
      end else begin
         case (r_state)
            REQ: begin
               if (w_accept) begin
                  r_req_pc <= r_pc;
                  r_state  <= WAIT;
                  r_drop   <= pc_sel;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  r_drop  <= 1'b0;
                  r_state <= REQ;
               end else if (pc_sel) begin
                  r_drop  <= 1'b1;
               end
            end
            default: r_state <= REQ;
         endcase
         if (pc_sel)        r_pc <= w_target;
         else if (w_accept) r_pc <= r_pc + XLEN'(PC_INC);
      end
   end

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (w_push),
      .push_data (w_push_entry),
      .pop       (w_pop),
      .flush     (pc_sel),
      .count     (w_count),
      .head      (w_head)
   );

   assign if_valid = reset_n && (w_count != '0);
   assign if_instr = w_head.instr;
   assign if_pc    = w_head.pc;

endmodule
